fpu_result_collector: RTL and testbench



---
 rtl/fpu_collector_pkg.sv | 60 ++++++
 rtl/fpu_rsp_fifo.sv | 61 ++++++
 rtl/fpu_result_collector.sv | 127 ++++++++++++
 tb/tb_fpu_result_collector.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_collector_pkg.sv
// Shared types for the FPU result collector: flag bit positions, tag and response payloads.
package fpu_collector_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FLAG_W  = 8;
  localparam int unsigned OP_W    = 3;
  localparam int unsigned RMODE_W = 2;

  localparam int unsigned FLG_INF  = 0;
  localparam int unsigned FLG_SNAN = 1;
  localparam int unsigned FLG_QNAN = 2;
  localparam int unsigned FLG_INE  = 3;
  localparam int unsigned FLG_OVF  = 4;
  localparam int unsigned FLG_UNF  = 5;
  localparam int unsigned FLG_ZERO = 6;
  localparam int unsigned FLG_DBZ  = 7;

  typedef logic [FLAG_W-1:0] fpu_flags_t;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [RMODE_W-1:0] rmode;
  } fpu_tag_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    fpu_flags_t        flags;
    fpu_tag_t          tag;
  } fpu_rsp_t;

  typedef struct packed {
    logic     valid;
    fpu_tag_t tag;
  } fpu_stage_t;

  // Gather the individual FPU status lines into the canonical flag vector.
  function automatic fpu_flags_t pack_flags(
    input logic inf,
    input logic snan,
    input logic qnan,
    input logic ine,
    input logic ovf,
    input logic unf,
    input logic zero,
    input logic dbz
  );
    fpu_flags_t f;
    f           = '0;
    f[FLG_INF]  = inf;
    f[FLG_SNAN] = snan;
    f[FLG_QNAN] = qnan;
    f[FLG_INE]  = ine;
    f[FLG_OVF]  = ovf;
    f[FLG_UNF]  = unf;
    f[FLG_ZERO] = zero;
    f[FLG_DBZ]  = dbz;
    return f;
  endfunction

endpackage

// File: rtl/fpu_rsp_fifo.sv
// Synchronous show-ahead FIFO of collected FPU responses; head is visible while valid.
module fpu_rsp_fifo
  import fpu_collector_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fpu_rsp_t         push_data,
  input  logic             pop,
  output fpu_rsp_t         head,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  fpu_rsp_t         mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;
  logic             full;

  assign do_pop = pop && (count_q != '0);
  assign full   = (count_q == CNT_W'(DEPTH));

  // Storage is cleared on reset so the head reads zero until the first capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

  // The issue-side credit scheme must never let a result land in a full FIFO.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !pop && full));

endmodule

// File: rtl/fpu_result_collector.sv
// Collects fixed-latency FPU results into a response FIFO, tracking in-flight ops by tag
// and accumulating sticky exception flags; issue credits prevent FIFO overflow.
module fpu_result_collector
  import fpu_collector_pkg::*;
#(
  parameter  int unsigned LATENCY = 4,
  parameter  int unsigned DEPTH   = 8,
  localparam int unsigned INF_W   = $clog2(LATENCY + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               issue_valid,
  output logic               issue_ready,
  input  logic [OP_W-1:0]    issue_op,
  input  logic [RMODE_W-1:0] issue_rmode,
  input  logic [DATA_W-1:0]  fpu_out,
  input  logic               fpu_inf,
  input  logic               fpu_snan,
  input  logic               fpu_qnan,
  input  logic               fpu_ine,
  input  logic               fpu_overflow,
  input  logic               fpu_underflow,
  input  logic               fpu_zero,
  input  logic               fpu_div_by_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [FLAG_W-1:0]  rsp_flags,
  output logic [OP_W-1:0]    rsp_op,
  output logic [RMODE_W-1:0] rsp_rmode,
  output logic [FLAG_W-1:0]  sticky_flags,
  input  logic               sticky_clr,
  output logic [INF_W-1:0]   inflight
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned CR_W  = $clog2(DEPTH + LATENCY + 1);

  fpu_stage_t       pipe_q [LATENCY];
  logic [INF_W-1:0] inflight_q;
  fpu_flags_t       sticky_q;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_valid;
  fpu_rsp_t         fifo_head;
  fpu_rsp_t         cap_rsp;
  fpu_flags_t       cap_flags;
  logic             accept;
  logic             capture;
  logic             pop;

  // Credits count both queued responses and results still inside the FPU.
  assign issue_ready = (CR_W'(fifo_count) + CR_W'(inflight_q)) < CR_W'(DEPTH);
  assign accept      = issue_valid & issue_ready;
  assign capture     = pipe_q[LATENCY-1].valid;
  assign pop         = fifo_valid & rsp_ready;

  assign cap_flags = pack_flags(fpu_inf, fpu_snan, fpu_qnan, fpu_ine,
                                fpu_overflow, fpu_underflow, fpu_zero, fpu_div_by_zero);

  always_comb begin
    cap_rsp       = '0;
    cap_rsp.data  = fpu_out;
    cap_rsp.flags = cap_flags;
    cap_rsp.tag   = pipe_q[LATENCY-1].tag;
  end

  // Tag pipe mirrors the FPU pipeline; it never stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0].valid     <= accept;
      pipe_q[0].tag.op    <= issue_op;
      pipe_q[0].tag.rmode <= issue_rmode;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
    end else begin
      case ({accept, capture})
        2'b10:   inflight_q <= inflight_q + INF_W'(1);
        2'b01:   inflight_q <= inflight_q - INF_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  // A clear coinciding with a capture keeps the newly captured flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
    end else if (capture) begin
      sticky_q <= (sticky_clr ? '0 : sticky_q) | cap_flags;
    end else if (sticky_clr) begin
      sticky_q <= '0;
    end
  end

  fpu_rsp_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (cap_rsp),
    .pop       (pop),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign rsp_valid    = fifo_valid;
  assign rsp_data     = fifo_head.data;
  assign rsp_flags    = fifo_head.flags;
  assign rsp_op       = fifo_head.tag.op;
  assign rsp_rmode    = fifo_head.tag.rmode;
  assign sticky_flags = sticky_q;
  assign inflight     = inflight_q;

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed bench for fpu_result_collector with a fixed-latency FPU stand-in and response scoreboard.
module tb_fpu_result_collector;
  import fpu_collector_pkg::*;

  localparam int unsigned LAT = 4;
  localparam int unsigned DEP = 8;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_op;
  logic [1:0]  issue_rmode;
  logic [31:0] fpu_out;
  logic        fpu_inf, fpu_snan, fpu_qnan, fpu_ine;
  logic        fpu_overflow, fpu_underflow, fpu_zero, fpu_div_by_zero;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [7:0]  rsp_flags;
  logic [2:0]  rsp_op;
  logic [1:0]  rsp_rmode;
  logic [7:0]  sticky_flags;
  logic        sticky_clr;
  logic [2:0]  inflight;

  // Result the FPU stand-in will produce for the op being issued.
  logic [31:0] issue_data;
  logic [7:0]  issue_flg;

  logic [LAT-1:0] fv = '0;
  logic [31:0]    fd [LAT];
  logic [7:0]     ff [LAT];
  logic           acc_pend = 1'b0;
  fpu_rsp_t       exp_q [$];

  int n_cmp = 0;
  int n_err = 0;
  int n_pop = 0;
  int pop0;

  fpu_result_collector #(.LATENCY(LAT), .DEPTH(DEP)) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_op        (issue_op),
    .issue_rmode     (issue_rmode),
    .fpu_out         (fpu_out),
    .fpu_inf         (fpu_inf),
    .fpu_snan        (fpu_snan),
    .fpu_qnan        (fpu_qnan),
    .fpu_ine         (fpu_ine),
    .fpu_overflow    (fpu_overflow),
    .fpu_underflow   (fpu_underflow),
    .fpu_zero        (fpu_zero),
    .fpu_div_by_zero (fpu_div_by_zero),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_data        (rsp_data),
    .rsp_flags       (rsp_flags),
    .rsp_op          (rsp_op),
    .rsp_rmode       (rsp_rmode),
    .sticky_flags    (sticky_flags),
    .sticky_clr      (sticky_clr),
    .inflight        (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // FPU stand-in: the presented result emerges LAT edges after its accept; idle bus carries junk.
  assign fpu_out = fv[LAT-1] ? fd[LAT-1] : 32'hDEAD_BEEF;
  assign {fpu_div_by_zero, fpu_zero, fpu_underflow, fpu_overflow,
          fpu_ine, fpu_qnan, fpu_snan, fpu_inf} = fv[LAT-1] ? ff[LAT-1] : 8'hFF;

  always @(posedge clk) begin
    fpu_rsp_t e;
    fv    <= {fv[LAT-2:0], acc_pend};
    fd[0] <= issue_data;
    ff[0] <= issue_flg;
    for (int i = 1; i < int'(LAT); i++) begin
      fd[i] <= fd[i-1];
      ff[i] <= ff[i-1];
    end
    if (acc_pend) begin
      e.data      = issue_data;
      e.flags     = issue_flg;
      e.tag.op    = issue_op;
      e.tag.rmode = issue_rmode;
      exp_q.push_back(e);
    end
  end

  // Accept decision and response scoreboard are sampled mid-cycle.
  always @(negedge clk) begin
    fpu_rsp_t h;
    acc_pend = issue_valid && issue_ready && !rst;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check("rsp_spurious", 64'(1), 64'(0));
      end else begin
        h = exp_q.pop_front();
        check("rsp_data", 64'(rsp_data), 64'(h.data));
        check("rsp_flags", 64'(rsp_flags), 64'(h.flags));
        check("rsp_tag", 64'({rsp_op, rsp_rmode}), 64'({h.tag.op, h.tag.rmode}));
        n_pop++;
      end
    end
  end

  initial begin
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_op    = '0;
    issue_rmode = '0;
    issue_data  = '0;
    issue_flg   = '0;
    rsp_ready   = 1'b0;
    sticky_clr  = 1'b0;
    repeat (2) step();

    check("rst_issue_ready", 64'(issue_ready), 64'(1));
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_data", 64'(rsp_data), 64'(0));
    check("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    check("rst_rsp_tag", 64'({rsp_op, rsp_rmode}), 64'(0));
    check("rst_sticky", 64'(sticky_flags), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    rst = 1'b0;
    step();

    // Single op 1.0 + 2.0 = 3.0
    issue_valid = 1'b1; issue_op = 3'b000; issue_rmode = 2'b00;
    issue_data  = 32'h4040_0000; issue_flg = 8'h00;
    step();
    issue_valid = 1'b0;
    check("t1_inflight_issue", 64'(inflight), 64'(1));
    for (int i = 1; i <= 4; i++) begin
      step();
      check("t1_rsp_valid", 64'(rsp_valid), 64'(i == 4));
    end
    check("t1_inflight_done", 64'(inflight), 64'(0));
    check("t1_data", 64'(rsp_data), 64'h4040_0000);
    check("t1_flags", 64'(rsp_flags), 64'(0));
    check("t1_op", 64'(rsp_op), 64'(0));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("t1_drained", 64'(rsp_valid), 64'(0));

    // Eight back-to-back accepts with the consumer stalled exhaust the credits
    for (int i = 0; i < 8; i++) begin
      check("t2_ready_pre", 64'(issue_ready), 64'(1));
      issue_valid = 1'b1; issue_op = 3'(i); issue_rmode = 2'(i);
      issue_data  = 32'h1000_0000 + 32'(i); issue_flg = 8'h00;
      step();
    end
    issue_valid = 1'b0;
    check("t2_ready_full", 64'(issue_ready), 64'(0));
    repeat (4) step();
    check("t2_inflight", 64'(inflight), 64'(0));
    check("t2_ready_still", 64'(issue_ready), 64'(0));
    check("t2_head_op", 64'(rsp_op), 64'(0));
    rsp_ready = 1'b1;
    step();
    check("t2_ready_after_pop", 64'(issue_ready), 64'(1));
    repeat (7) step();
    rsp_ready = 1'b0;
    check("t2_empty", 64'(rsp_valid), 64'(0));
    check("t2_scoreboard", 64'(exp_q.size()), 64'(0));
    check("t2_pops", 64'(n_pop), 64'(9));

    // 1.0/0.0 sets inf|dbz; a clear coinciding with an inexact capture leaves only ine
    rsp_ready = 1'b1;
    issue_valid = 1'b1; issue_op = 3'b011; issue_rmode = 2'b00;
    issue_data  = 32'h7F80_0000; issue_flg = 8'h81;
    step();
    issue_valid = 1'b0;
    repeat (4) step();
    check("t3_sticky_dbz", 64'(sticky_flags), 64'h81);
    issue_valid = 1'b1; issue_op = 3'b011; issue_rmode = 2'b00;
    issue_data  = 32'h3EAA_AAAB; issue_flg = 8'h08;
    step();
    issue_valid = 1'b0;
    repeat (3) step();
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("t3_sticky_clr_cap", 64'(sticky_flags), 64'h08);
    sticky_clr = 1'b1;
    step();
    sticky_clr = 1'b0;
    check("t3_sticky_clr", 64'(sticky_flags), 64'h00);
    repeat (2) step();
    check("t3_scoreboard", 64'(exp_q.size()), 64'(0));

    // Continuous stream of 20 ops with an always-ready consumer
    pop0 = n_pop;
    for (int i = 0; i < 20; i++) begin
      check("t4_ready", 64'(issue_ready), 64'(1));
      issue_valid = 1'b1; issue_op = 3'((i * 3) % 8); issue_rmode = 2'(i % 4);
      issue_data  = 32'hC000_0000 + 32'(i * 17); issue_flg = 8'(1 << (i % 8));
      step();
      if (i >= int'(LAT)) check("t4_stream_valid", 64'(rsp_valid), 64'(1));
    end
    issue_valid = 1'b0;
    for (int j = 0; j < int'(LAT); j++) begin
      step();
      check("t4_tail_valid", 64'(rsp_valid), 64'(1));
    end
    step();
    check("t4_idle", 64'(rsp_valid), 64'(0));
    check("t4_pops", 64'(n_pop - pop0), 64'(20));
    check("t4_sticky", 64'(sticky_flags), 64'hFF);

    // Reset with three results in the FPU and two queued
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      issue_valid = 1'b1; issue_op = 3'(i + 1); issue_rmode = 2'(i);
      issue_data  = 32'h2000_0000 + 32'(i); issue_flg = 8'h10;
      step();
    end
    issue_valid = 1'b0;
    step();
    check("t5_inflight_pre", 64'(inflight), 64'(3));
    check("t5_valid_pre", 64'(rsp_valid), 64'(1));
    rst = 1'b1;
    step();
    check("t5_rst_valid", 64'(rsp_valid), 64'(0));
    check("t5_rst_inflight", 64'(inflight), 64'(0));
    check("t5_rst_ready", 64'(issue_ready), 64'(1));
    check("t5_rst_sticky", 64'(sticky_flags), 64'(0));
    exp_q.delete();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      check("t5_no_stale", 64'(rsp_valid), 64'(0));
    end
    check("t5_sticky_post", 64'(sticky_flags), 64'(0));
    check("t5_inflight_post", 64'(inflight), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
